axil_cfg_master: RTL and testbench

- AXI-Lite initiator that issues single register writes/reads into the user project's AXI-Lite target port.
- Accepts commands on a valid/ready command interface, runs exactly one AXI-Lite transaction per command, and returns read data or completion status on a valid/ready response interface.
- The write path has no B channel: a write completes when both the AW and W handshakes are done.
- A per-transaction timeout recovers from a target that never responds.

---
 rtl/axil_cfg_master.sv | 184 ++++++++++++++++++
 tb/tb_axil_cfg_master.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/axil_cfg_master.sv
// AXI-Lite configuration initiator: one single-beat write or read per command,
// with a per-phase handshake timeout and a registered response channel.
module axil_cfg_master #(
  parameter int pADDR_WIDTH = 12,
  parameter int pDATA_WIDTH = 32,
  parameter int pTIMEOUT    = 255
) (
  input  logic                   ALCLK,
  input  logic                   ARESET,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic                   cmd_write,
  input  logic [pADDR_WIDTH-1:0] cmd_addr,
  input  logic [pDATA_WIDTH-1:0] cmd_wdata,
  input  logic [3:0]             cmd_wstrb,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [pDATA_WIDTH-1:0] rsp_rdata,
  output logic                   rsp_err,
  output logic                   awvalid,
  input  logic                   awready,
  output logic [pADDR_WIDTH-1:0] awaddr,
  output logic                   wvalid,
  input  logic                   wready,
  output logic [pDATA_WIDTH-1:0] wdata,
  output logic [3:0]             wstrb,
  output logic                   arvalid,
  input  logic                   arready,
  output logic [pADDR_WIDTH-1:0] araddr,
  input  logic                   rvalid,
  output logic                   rready,
  input  logic [pDATA_WIDTH-1:0] rdata
);

  localparam int TW = $clog2(pTIMEOUT + 1);
  localparam logic [TW-1:0] TIMER_LAST = TW'(pTIMEOUT - 1);

  typedef enum logic [2:0] {IDLE, WR, RD_A, RD_D, RSP} state_t;

  state_t                  state_q, state_d;
  logic [TW-1:0]           timer_q, timer_d;
  logic [pADDR_WIDTH-1:0]  addr_q;
  logic                    accept;
  logic                    aw_done, w_done, timed_out;
  logic                    cmd_ready_d, awvalid_d, wvalid_d, arvalid_d, rready_d;
  logic                    rsp_valid_d, rsp_err_d;
  logic [pDATA_WIDTH-1:0]  rsp_rdata_d;

  assign accept = (state_q == IDLE) && cmd_valid && cmd_ready;
  assign awaddr = addr_q;
  assign araddr = addr_q;

  always_ff @(posedge ALCLK) begin
    if (ARESET) begin
      state_q   <= IDLE;
      timer_q   <= '0;
      addr_q    <= '0;
      wdata     <= '0;
      wstrb     <= '0;
      cmd_ready <= 1'b1;
      awvalid   <= 1'b0;
      wvalid    <= 1'b0;
      arvalid   <= 1'b0;
      rready    <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      cmd_ready <= cmd_ready_d;
      awvalid   <= awvalid_d;
      wvalid    <= wvalid_d;
      arvalid   <= arvalid_d;
      rready    <= rready_d;
      rsp_valid <= rsp_valid_d;
      rsp_rdata <= rsp_rdata_d;
      rsp_err   <= rsp_err_d;
      if (accept) begin
        addr_q <= cmd_addr;
        wdata  <= cmd_wdata;
        wstrb  <= cmd_wstrb;
      end
    end
  end

  // A channel counts as done once its valid has dropped or it handshakes this edge.
  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    cmd_ready_d = cmd_ready;
    awvalid_d   = awvalid;
    wvalid_d    = wvalid;
    arvalid_d   = arvalid;
    rready_d    = rready;
    rsp_valid_d = rsp_valid;
    rsp_rdata_d = rsp_rdata;
    rsp_err_d   = rsp_err;
    aw_done     = !awvalid || awready;
    w_done      = !wvalid || wready;
    timed_out   = (timer_q == TIMER_LAST);

    case (state_q)
      IDLE: begin
        if (accept) begin
          cmd_ready_d = 1'b0;
          timer_d     = '0;
          if (cmd_write) begin
            state_d   = WR;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
          end else begin
            state_d   = RD_A;
            arvalid_d = 1'b1;
          end
        end
      end
      WR: begin
        timer_d = timer_q + TW'(1);
        if (awvalid && awready) awvalid_d = 1'b0;
        if (wvalid && wready)   wvalid_d  = 1'b0;
        if (aw_done && w_done) begin
          state_d     = RSP;
          rsp_err_d   = 1'b0;
          rsp_rdata_d = '0;
        end else if (timed_out) begin
          state_d     = RSP;
          awvalid_d   = 1'b0;
          wvalid_d    = 1'b0;
          rsp_err_d   = 1'b1;
          rsp_rdata_d = '0;
        end
      end
      RD_A: begin
        timer_d = timer_q + TW'(1);
        if (arready) begin
          state_d   = RD_D;
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          timer_d   = '0;
        end else if (timed_out) begin
          state_d     = RSP;
          arvalid_d   = 1'b0;
          rsp_err_d   = 1'b1;
          rsp_rdata_d = '0;
        end
      end
      RD_D: begin
        timer_d = timer_q + TW'(1);
        if (rvalid) begin
          state_d     = RSP;
          rready_d    = 1'b0;
          rsp_rdata_d = rdata;
          rsp_err_d   = 1'b0;
        end else if (timed_out) begin
          state_d     = RSP;
          rready_d    = 1'b0;
          rsp_err_d   = 1'b1;
          rsp_rdata_d = '0;
        end
      end
      RSP: begin
        // rsp_valid rises one cycle after entry; the next command is only taken after the handshake
        if (rsp_valid && rsp_ready) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b0;
          cmd_ready_d = 1'b1;
        end else begin
          rsp_valid_d = 1'b1;
        end
      end
      default: begin
        state_d     = IDLE;
        cmd_ready_d = 1'b1;
        awvalid_d   = 1'b0;
        wvalid_d    = 1'b0;
        arvalid_d   = 1'b0;
        rready_d    = 1'b0;
        rsp_valid_d = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_axil_cfg_master.sv
// Self-checking bench for axil_cfg_master: directed and random transactions against a
// cycle-count reference model and a simple AXI-Lite target memory.
module tb_axil_cfg_master;

  localparam int AW = 12;
  localparam int DW = 32;
  localparam int TO = 8;

  logic          ALCLK = 1'b0;
  logic          ARESET = 1'b1;
  logic          cmd_valid, cmd_ready, cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic [3:0]    cmd_wstrb;
  logic          rsp_valid, rsp_ready, rsp_err;
  logic [DW-1:0] rsp_rdata;
  logic          awvalid, awready, wvalid, wready, arvalid, arready, rvalid, rready;
  logic [AW-1:0] awaddr, araddr;
  logic [DW-1:0] wdata, rdata;
  logic [3:0]    wstrb;

  int vectors = 0;
  int miscompares = 0;

  logic [DW-1:0] model_mem [int];
  logic [DW-1:0] tgt_mem [int];

  always #5 ALCLK = ~ALCLK;

  axil_cfg_master #(.pADDR_WIDTH(AW), .pDATA_WIDTH(DW), .pTIMEOUT(TO)) dut (
    .ALCLK(ALCLK), .ARESET(ARESET),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .awvalid(awvalid), .awready(awready), .awaddr(awaddr),
    .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb),
    .arvalid(arvalid), .arready(arready), .araddr(araddr),
    .rvalid(rvalid), .rready(rready), .rdata(rdata)
  );

  function automatic logic [DW-1:0] initWord(input int a);
    return {20'hC0DE0, 12'(a)};
  endfunction

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] nw,
                                          input logic [3:0] strb);
    logic [DW-1:0] r;
    r = old;
    for (int i = 0; i < 4; i++) if (strb[i]) r[8*i +: 8] = nw[8*i +: 8];
    return r;
  endfunction

  function automatic logic [DW-1:0] modelRead(input int a);
    return model_mem.exists(a) ? model_mem[a] : initWord(a);
  endfunction

  function automatic logic [DW-1:0] tgtRead(input int a);
    return tgt_mem.exists(a) ? tgt_mem[a] : initWord(a);
  endfunction

  // {cmd_ready, awvalid, wvalid, arvalid, rready, rsp_valid}
  function automatic logic [5:0] flags();
    return {cmd_ready, awvalid, wvalid, arvalid, rready, rsp_valid};
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // One full command: called and returns at #1 after a rising edge with the DUT idle.
  // a_at/b_at are the edges (counted from acceptance) at which the target first becomes ready.
  task automatic applyStimulus(input bit wr, input logic [AW-1:0] addr, input logic [DW-1:0] data,
                               input logic [3:0] strb, input int a_at, input int b_at, input int hold);
    int end_edge, aw_last, w_last, ar_last, rd_first, rd_last;
    bit err, got_aw, got_w, got_ar;
    logic [DW-1:0] exp_rdata, t_wdata;
    logic [AW-1:0] t_awaddr, t_araddr;
    logic [3:0] t_wstrb;
    logic [5:0] exp_f;

    aw_last = 0; w_last = 0; ar_last = 0; rd_first = 1; rd_last = 0;
    got_aw = 0; got_w = 0; got_ar = 0;
    t_wdata = '0; t_awaddr = '0; t_araddr = '0; t_wstrb = '0;
    if (wr) begin
      aw_last  = (a_at < TO) ? a_at : TO;
      w_last   = (b_at < TO) ? b_at : TO;
      err      = (a_at > TO) || (b_at > TO);
      end_edge = err ? TO : ((a_at > b_at) ? a_at : b_at);
    end else if (a_at > TO) begin
      ar_last  = TO;
      err      = 1'b1;
      end_edge = TO;
    end else begin
      ar_last  = a_at;
      rd_first = a_at + 1;
      err      = (b_at > a_at + TO);
      rd_last  = err ? a_at + TO : b_at;
      end_edge = rd_last;
    end
    exp_rdata = (wr || err) ? '0 : modelRead(int'(addr));

    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = data; cmd_wstrb = strb;
    @(negedge ALCLK);
    checkOutput("idle flags", 64'(flags()), 64'(6'b100000));
    @(posedge ALCLK); #1;
    cmd_valid = 1'b0; cmd_write = 1'($urandom); cmd_addr = AW'($urandom);
    cmd_wdata = $urandom; cmd_wstrb = 4'($urandom);

    for (int c = 1; c <= end_edge + 1; c++) begin
      awready = wr && (c >= a_at);
      wready  = wr && (c >= b_at);
      arready = !wr && (c >= a_at);
      rvalid  = !wr && (c >= b_at);
      rdata   = (rvalid && got_ar) ? tgtRead(int'(t_araddr)) : $urandom;
      @(negedge ALCLK);
      exp_f = {1'b0, wr && (c <= aw_last), wr && (c <= w_last), !wr && (c <= ar_last),
               !wr && (c >= rd_first) && (c <= rd_last), 1'b0};
      checkOutput($sformatf("flags c%0d", c), 64'(flags()), 64'(exp_f));
      if (exp_f[4]) checkOutput("awaddr", 64'(awaddr), 64'(addr));
      if (exp_f[3]) checkOutput("wdata/wstrb", 64'({wstrb, wdata}), 64'({strb, data}));
      if (exp_f[2]) checkOutput("araddr", 64'(araddr), 64'(addr));
      if (awvalid && awready) begin got_aw = 1; t_awaddr = awaddr; end
      if (wvalid && wready) begin got_w = 1; t_wdata = wdata; t_wstrb = wstrb; end
      if (got_aw && got_w) begin
        tgt_mem[int'(t_awaddr)] = merge(tgtRead(int'(t_awaddr)), t_wdata, t_wstrb);
        got_aw = 0; got_w = 0;
      end
      if (arvalid && arready) begin got_ar = 1; t_araddr = araddr; end
      @(posedge ALCLK); #1;
    end
    awready = 0; wready = 0; arready = 0; rvalid = 0;

    for (int h = 0; h <= hold; h++) begin
      rsp_ready = (h == hold);
      @(negedge ALCLK);
      checkOutput("rsp flags", 64'(flags()), 64'(6'b000001));
      checkOutput("rsp_rdata", 64'(rsp_rdata), 64'(exp_rdata));
      checkOutput("rsp_err", 64'(rsp_err), 64'(err));
      @(posedge ALCLK); #1;
    end
    rsp_ready = 1'b0;
    @(negedge ALCLK);
    checkOutput("rsp drop", 64'(flags()), 64'(6'b100000));
    @(posedge ALCLK); #1;
    if (wr && !err) model_mem[int'(addr)] = merge(modelRead(int'(addr)), data, strb);
  endtask

  initial begin
    bit wr;
    int a, b;
    cmd_valid = 0; cmd_write = 0; cmd_addr = '0; cmd_wdata = '0; cmd_wstrb = '0;
    rsp_ready = 0; awready = 0; wready = 0; arready = 0; rvalid = 0; rdata = '0;
    repeat (2) @(posedge ALCLK);
    #1 ARESET = 1'b0;
    @(negedge ALCLK);
    checkOutput("reset flags", 64'(flags()), 64'(6'b100000));
    checkOutput("reset busses", 64'({awaddr, araddr, wstrb, rsp_err}), 64'(0));
    checkOutput("reset data", 64'({wdata, rsp_rdata}), 64'(0));
    @(posedge ALCLK); #1;

    $display("[TB] directed transactions");
    applyStimulus(1, 12'h010, 32'hA5A5_0001, 4'hF, 1, 1, 0);
    applyStimulus(1, 12'h024, 32'h1234_5678, 4'hF, 1, 4, 0);
    applyStimulus(0, 12'h024, '0, 4'h0, 2, 5, 0);
    applyStimulus(0, 12'h030, '0, 4'h0, 100, 200, 0);
    applyStimulus(0, 12'h010, '0, 4'h0, 1, 2, 0);
    applyStimulus(1, 12'h040, 32'hDEAD_BEEF, 4'hF, 8, 9, 0);
    applyStimulus(0, 12'h044, '0, 4'h0, 8, 16, 0);
    applyStimulus(0, 12'h048, '0, 4'h0, 3, 12, 0);
    applyStimulus(1, 12'h044, 32'h5566_7788, 4'b0101, 3, 2, 5);
    applyStimulus(0, 12'h044, '0, 4'h0, 1, 2, 5);

    $display("[TB] reset during write");
    cmd_valid = 1; cmd_write = 1; cmd_addr = 12'h050; cmd_wdata = 32'hFFFF_0000; cmd_wstrb = 4'hF;
    @(posedge ALCLK); #1;
    cmd_valid = 0;
    @(negedge ALCLK);
    checkOutput("pre-reset WR", 64'(flags()), 64'(6'b011000));
    ARESET = 1'b1;
    @(posedge ALCLK); #1;
    ARESET = 1'b0;
    @(negedge ALCLK);
    checkOutput("post-reset flags", 64'(flags()), 64'(6'b100000));
    for (int i = 0; i < 3; i++) begin
      @(posedge ALCLK); #1;
      @(negedge ALCLK);
      checkOutput("no response after reset", 64'(flags()), 64'(6'b100000));
    end
    @(posedge ALCLK); #1;
    applyStimulus(0, 12'h050, '0, 4'h0, 1, 2, 0);

    $display("[TB] random transactions");
    for (int n = 0; n < 40; n++) begin
      wr = 1'($urandom_range(0, 1));
      a  = $urandom_range(1, 10);
      b  = wr ? $urandom_range(1, 10) : a + $urandom_range(1, 10);
      applyStimulus(wr, AW'(12'h100 + $urandom_range(0, 23)), $urandom, 4'($urandom_range(0, 15)),
                    a, b, $urandom_range(0, 3));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
